// File: rtl/invsqrt_result_sink.sv
// Result sink for the invsqrt pipeline: FWFT FIFO, sign restore, early backpressure.
// Optional statistics counters (n_in/n_drop) are enabled by defining INVSQRT_SINK_STATS_EN.
module invsqrt_result_sink #(
    parameter int DEPTH = 16,
    parameter int SKID  = 8
`ifdef INVSQRT_SINK_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     res_valid,
    input  logic [30:0]              res_data,
    output logic                     backprn,
    output logic [31:0]              m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
`ifdef INVSQRT_SINK_STATS_EN
    ,
    output logic [CNT_W-1:0]         n_in,
    output logic [CNT_W-1:0]         n_drop
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          backprn_q, backprn_d;
    logic          ovf_q, ovf_d;
    logic [30:0]   mem_q [DEPTH];
    logic          full_s, empty_s, pop_s, push_s, drop_s;

    // Handshake decode and next-state for pointers, occupancy and flags.
    always_comb begin
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s    = !empty_s && m_ready;
        // A same-cycle pop frees the head slot, so a push into a full FIFO is legal then.
        push_s   = res_valid && (!full_s || pop_s);
        drop_s   = res_valid && full_s && !pop_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
        endcase
        // Equivalent to (DEPTH - level_d) > SKID without unsigned underflow.
        backprn_d = (level_d < PW'(DEPTH - SKID));
        ovf_d     = ovf_q || drop_s;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            level_q   <= {PW{1'b0}};
            backprn_q <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            backprn_q <= backprn_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= res_data;
        end
    end

    // Output view: head word with the implied zero sign bit, zero when empty.
    always_comb begin
        m_valid = !empty_s;
        if (empty_s) begin
            m_data = 32'h0000_0000;
        end else begin
            m_data = {1'b0, mem_q[rd_ptr_q[AW-1:0]]};
        end
        level   = level_q;
        backprn = backprn_q;
        ovf     = ovf_q;
    end

`ifdef INVSQRT_SINK_STATS_EN
    logic [CNT_W-1:0] n_in_q, n_in_d;
    logic [CNT_W-1:0] n_drop_q, n_drop_d;

    // Saturating accepted/dropped counters.
    always_comb begin
        n_in_d   = n_in_q;
        n_drop_d = n_drop_q;
        if (push_s && (n_in_q != {CNT_W{1'b1}})) begin
            n_in_d = n_in_q + CNT_W'(1);
        end else begin
            n_in_d = n_in_q;
        end
        if (drop_s && (n_drop_q != {CNT_W{1'b1}})) begin
            n_drop_d = n_drop_q + CNT_W'(1);
        end else begin
            n_drop_d = n_drop_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_in_q   <= {CNT_W{1'b0}};
            n_drop_q <= {CNT_W{1'b0}};
        end else begin
            n_in_q   <= n_in_d;
            n_drop_q <= n_drop_d;
        end
    end

    assign n_in   = n_in_q;
    assign n_drop = n_drop_q;
`endif

endmodule
